// File: rtl/fpu_op_sequencer.sv
// Issue/latency/response sequencer for the shared FPU datapath and its exception-flag unit.
// Optional FPU_SEQ_BACK2BACK_EN: a request may be accepted in the same cycle as the response handshake.
//   state | meaning
//   IDLE  | waiting for a request
//   EXEC  | datapath running, cnt counting down to the result cycle
//   FLAG  | sampling registered exception flags, accruing fflags
//   RESP  | presenting result/flags/tag until the response handshake
module fpu_op_sequencer #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 3,
  parameter int LAT_FMA  = 4,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 12,
  parameter int TAG_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       req_op_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [31:0]      req_c_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             dp_start_o,
  output logic [3:0]       dp_op_o,
  output logic [31:0]      dp_a_o,
  output logic [31:0]      dp_b_o,
  output logic [31:0]      dp_c_o,
  input  logic [31:0]      dp_result_i,
  input  logic [4:0]       exc_flags_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic [4:0]       rsp_flags_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [4:0]       fflags_o,
  input  logic             csr_we_i,
  input  logic [4:0]       csr_wdata_i,
  output logic             busy_o
);

  localparam logic [3:0] OP_FADD   = 4'd0;
  localparam logic [3:0] OP_FSUB   = 4'd1;
  localparam logic [3:0] OP_FMUL   = 4'd2;
  localparam logic [3:0] OP_FDIV   = 4'd3;
  localparam logic [3:0] OP_FSQRT  = 4'd4;
  localparam logic [3:0] OP_FMADD  = 4'd5;
  localparam logic [3:0] OP_FMSUB  = 4'd6;
  localparam logic [3:0] OP_FNMADD = 4'd7;
  localparam logic [3:0] OP_FNMSUB = 4'd8;

  localparam int LAT_M0  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LAT_M1  = (LAT_M0 > LAT_FMA) ? LAT_M0 : LAT_FMA;
  localparam int LAT_M2  = (LAT_M1 > LAT_DIV) ? LAT_M1 : LAT_DIV;
  localparam int LAT_MAX = (LAT_M2 > LAT_SQRT) ? LAT_M2 : LAT_SQRT;
  localparam int CNT_W   = $clog2(LAT_MAX) + 1;

  if (LAT_ADD < 1 || LAT_MUL < 1 || LAT_FMA < 1 || LAT_DIV < 1 || LAT_SQRT < 1) begin : g_lat_check
    $error("fpu_op_sequencer: every LAT_* parameter must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FLAG, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_first;
  logic [3:0]         r_op;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [31:0]        r_c;
  logic [TAG_W-1:0]   r_tag;
  logic [31:0]        r_result;
  logic [4:0]         r_flags;
  logic [4:0]         r_fflags;
  logic               w_req_ready;
  logic               w_accept;
  logic               w_rsp_valid;
  logic               w_cap_res;

  function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
    int lat;
    case (op)
      OP_FADD, OP_FSUB:                        lat = LAT_ADD;
      OP_FMUL:                                 lat = LAT_MUL;
      OP_FDIV:                                 lat = LAT_DIV;
      OP_FSQRT:                                lat = LAT_SQRT;
      OP_FMADD, OP_FMSUB, OP_FNMADD, OP_FNMSUB: lat = LAT_FMA;
      default:                                 lat = 1;
    endcase
    return CNT_W'(lat - 1);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_accept    = 1'b0;
    w_rsp_valid = 1'b0;
    w_cap_res   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_cap_res   = 1'b1;
          w_state_nxt = S_FLAG;
        end
      end
      S_FLAG: w_state_nxt = S_RESP;
      S_RESP: begin
        w_rsp_valid = 1'b1;
`ifdef FPU_SEQ_BACK2BACK_EN
        w_req_ready = rsp_ready_i;
`endif
        if (rsp_ready_i) begin
          w_state_nxt = S_IDLE;
`ifdef FPU_SEQ_BACK2BACK_EN
          // Skip IDLE when the next request is already waiting.
          if (req_valid_i) begin
            w_accept    = 1'b1;
            w_state_nxt = S_EXEC;
          end
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_first  <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_tag    <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_fflags <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_first <= w_accept;
      if (w_accept) begin
        r_op  <= req_op_i;
        r_a   <= req_a_i;
        r_b   <= req_b_i;
        r_c   <= req_c_i;
        r_tag <= req_tag_i;
        r_cnt <= lat_m1(req_op_i);
      end else if (r_state == S_EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_cap_res) r_result <= dp_result_i;
      // CSR write lands first so flags raised by the finishing op are never lost.
      if (r_state == S_FLAG) begin
        r_flags  <= exc_flags_i;
        r_fflags <= (csr_we_i ? csr_wdata_i : r_fflags) | exc_flags_i;
      end else if (csr_we_i) begin
        r_fflags <= csr_wdata_i;
      end
    end
  end

  assign req_ready_o  = w_req_ready;
  assign dp_start_o   = r_first;
  assign dp_op_o      = r_op;
  assign dp_a_o       = r_a;
  assign dp_b_o       = r_b;
  assign dp_c_o       = r_c;
  assign rsp_valid_o  = w_rsp_valid;
  assign rsp_result_o = r_result;
  assign rsp_flags_o  = r_flags;
  assign rsp_tag_o    = r_tag;
  assign fflags_o     = r_fflags;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer with timed datapath/exception models and a response scoreboard.
`timescale 1ns/1ps
module tb_fpu_op_sequencer;
  localparam logic [3:0] OP_FADD  = 4'd0;
  localparam logic [3:0] OP_FSUB  = 4'd1;
  localparam logic [3:0] OP_FMUL  = 4'd2;
  localparam logic [3:0] OP_FDIV  = 4'd3;
  localparam logic [3:0] OP_FSQRT = 4'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0, req_c = '0;
  logic [3:0]  req_tag = '0;
  logic        dp_start;
  logic [3:0]  dp_op;
  logic [31:0] dp_a, dp_b, dp_c;
  logic [31:0] dp_result;
  logic [4:0]  exc_flags;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic [3:0]  rsp_tag;
  logic [4:0]  fflags;
  logic        csr_we = 1'b0;
  logic [4:0]  csr_wdata = '0;
  logic        busy;

  fpu_op_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c), .req_tag_i(req_tag),
    .dp_start_o(dp_start), .dp_op_o(dp_op), .dp_a_o(dp_a), .dp_b_o(dp_b), .dp_c_o(dp_c),
    .dp_result_i(dp_result), .exc_flags_i(exc_flags),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_flags_o(rsp_flags), .rsp_tag_o(rsp_tag), .fflags_o(fflags),
    .csr_we_i(csr_we), .csr_wdata_i(csr_wdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  logic [4:0] exp_fflags = '0;

  function automatic int tb_lat(input logic [3:0] op);
    case (op)
      OP_FADD, OP_FSUB: return 2;
      OP_FMUL:          return 3;
      OP_FDIV:          return 12;
      OP_FSQRT:         return 12;
      4'd5, 4'd6, 4'd7, 4'd8: return 4;
      default:          return 1;
    endcase
  endfunction

  function automatic logic [31:0] tb_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    if (op == OP_FADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[15:0], b[31:16]} ^ (c << 1) ^ {28'h0, op};
  endfunction

  // Datapath drives a valid result only LAT-1 cycles after the start pulse; flags one cycle later.
  int age = 100;
  int tb_k;
  logic [4:0] tb_flags = '0;
  always @(posedge clk) begin
    if (dp_start) age <= 1;
    else if (age < 100) age <= age + 1;
  end
  assign tb_k = dp_start ? 0 : age;
  always_comb begin
    dp_result = (tb_k == tb_lat(dp_op) - 1) ? tb_res(dp_op, dp_a, dp_b, dp_c) : 32'hDEADBEEF;
    exc_flags = (tb_k == tb_lat(dp_op)) ? tb_flags : 5'b11111;
  end

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb[$];

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [3:0] tag, input logic [4:0] fl,
                       output int t_acc, output bit ok);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_c = c; req_tag = tag;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    ok = req_ready;
    t_acc = cyc;
    if (ok) begin
      sb.push_back('{res: tb_res(op, a, b, c), fl: fl, tag: tag});
      tb_flags = fl;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int t, output bit ok);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    ok = rsp_valid;
    t = cyc;
  endtask

  task automatic test_reset;
    n_total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%b exp=1", req_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0 || dp_start !== 1'b0) $display("FAIL rst_valid_start got=%b%b exp=00", rsp_valid, dp_start); else n_pass++;
    n_total++; if (fflags !== 5'b0 || rsp_result !== 32'h0) $display("FAIL rst_regs got fflags=%b res=%h exp=0", fflags, rsp_result); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_after got busy=%b ready=%b exp busy=0 ready=1", busy, req_ready); else n_pass++;
  endtask

  task automatic test_fadd;
    int t, tr; bit ok; exp_t e;
    issue(OP_FADD, 32'h3F800000, 32'h40000000, 32'h0, 4'd3, 5'b00001, t, ok);
    n_total++; if (!ok) $display("FAIL fadd_accept got=timeout exp=accept"); else n_pass++;
    n_total++; if (dp_start !== 1'b1) $display("FAIL fadd_start_t1 got=%b exp=1", dp_start); else n_pass++;
    @(negedge clk);
    n_total++; if (dp_start !== 1'b0) $display("FAIL fadd_start_t2 got=%b exp=0", dp_start); else n_pass++;
    wait_rsp(tr, ok);
    n_total++; if (!ok || tr != t + 4) $display("FAIL fadd_rsp_cycle got=%0d exp=%0d", tr - t, 4); else n_pass++;
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      n_total++; if (rsp_result !== e.res) $display("FAIL fadd_result got=%h exp=%h", rsp_result, e.res); else n_pass++;
      n_total++; if (rsp_flags !== e.fl || rsp_tag !== e.tag) $display("FAIL fadd_flags_tag got=%b/%0d exp=%b/%0d", rsp_flags, rsp_tag, e.fl, e.tag); else n_pass++;
    end
    exp_fflags = exp_fflags | 5'b00001;
    n_total++; if (fflags !== exp_fflags) $display("FAIL fadd_fflags got=%b exp=%b", fflags, exp_fflags); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_fdiv_sticky;
    int t, tr; bit ok; exp_t e;
    issue(OP_FDIV, 32'h3F800000, 32'h00000000, 32'h0, 4'd4, 5'b01001, t, ok);
    wait_rsp(tr, ok);
    n_total++; if (!ok || tr != t + 14) $display("FAIL fdiv_rsp_cycle got=%0d exp=%0d", tr - t, 14); else n_pass++;
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      n_total++; if (rsp_result !== e.res || rsp_flags !== e.fl || rsp_tag !== e.tag) $display("FAIL fdiv_rsp got=%h/%b/%0d exp=%h/%b/%0d", rsp_result, rsp_flags, rsp_tag, e.res, e.fl, e.tag); else n_pass++;
    end
    exp_fflags = exp_fflags | 5'b01001;
    n_total++; if (fflags !== exp_fflags) $display("FAIL fdiv_fflags got=%b exp=%b", fflags, exp_fflags); else n_pass++;
    @(negedge clk);
    issue(OP_FADD, 32'h40000000, 32'h40400000, 32'h0, 4'd5, 5'b00000, t, ok);
    wait_rsp(tr, ok);
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      n_total++; if (rsp_result !== e.res || rsp_flags !== e.fl || rsp_tag !== e.tag) $display("FAIL clean_fadd_rsp got=%h/%b/%0d exp=%h/%b/%0d", rsp_result, rsp_flags, rsp_tag, e.res, e.fl, e.tag); else n_pass++;
    end
    n_total++; if (fflags !== exp_fflags) $display("FAIL fflags_sticky got=%b exp=%b", fflags, exp_fflags); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_stall;
    int t, tr; bit ok, bad; exp_t e;
    rsp_ready = 1'b0;
    issue(OP_FMUL, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 4'd7, 5'b00100, t, ok);
    wait_rsp(tr, ok);
    n_total++; if (!ok || tr != t + 5) $display("FAIL fmul_rsp_cycle got=%0d exp=%0d", tr - t, 5); else n_pass++;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_result !== e.res || rsp_flags !== e.fl || rsp_tag !== e.tag ||
          req_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    n_total++; if (bad) $display("FAIL stall_hold got=%h/%b/%0d ready=%b busy=%b exp=%h/%b/%0d ready=0 busy=1", rsp_result, rsp_flags, rsp_tag, req_ready, busy, e.res, e.fl, e.tag); else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_total++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL stall_release got busy=%b ready=%b valid=%b exp 0/1/0", busy, req_ready, rsp_valid); else n_pass++;
    exp_fflags = exp_fflags | 5'b00100;
    n_total++; if (fflags !== exp_fflags) $display("FAIL stall_fflags got=%b exp=%b", fflags, exp_fflags); else n_pass++;
  endtask

  task automatic test_csr;
    int t, tr; bit ok; exp_t e;
    issue(OP_FSUB, 32'h40800000, 32'h3F800000, 32'h0, 4'd9, 5'b10000, t, ok);
    while (cyc < t + 3) @(negedge clk);
    n_total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL csr_flag_cycle got busy=%b valid=%b exp 1/0", busy, rsp_valid); else n_pass++;
    csr_we = 1'b1; csr_wdata = 5'b00000;
    @(negedge clk);
    csr_we = 1'b0;
    exp_fflags = 5'b10000;
    n_total++; if (fflags !== exp_fflags) $display("FAIL csr_in_flag got=%b exp=%b", fflags, exp_fflags); else n_pass++;
    wait_rsp(tr, ok);
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      n_total++; if (rsp_result !== e.res || rsp_flags !== e.fl || rsp_tag !== e.tag) $display("FAIL fsub_rsp got=%h/%b/%0d exp=%h/%b/%0d", rsp_result, rsp_flags, rsp_tag, e.res, e.fl, e.tag); else n_pass++;
    end
    @(negedge clk);
    csr_we = 1'b1; csr_wdata = 5'b00110;
    @(negedge clk);
    exp_fflags = 5'b00110;
    n_total++; if (fflags !== exp_fflags) $display("FAIL csr_write got=%b exp=%b", fflags, exp_fflags); else n_pass++;
    csr_wdata = 5'b00000;
    @(negedge clk);
    csr_we = 1'b0;
    exp_fflags = 5'b00000;
    n_total++; if (fflags !== exp_fflags) $display("FAIL csr_clear got=%b exp=%b", fflags, exp_fflags); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int t, tr; bit ok, bad; exp_t e;
    csr_we = 1'b1; csr_wdata = 5'b00011;
    @(negedge clk);
    csr_we = 1'b0;
    issue(OP_FDIV, 32'h41200000, 32'h40000000, 32'h0, 4'd6, 5'b00010, t, ok);
    while (cyc < t + 5) @(negedge clk);
    n_total++; if (busy !== 1'b1 || fflags !== 5'b00011) $display("FAIL pre_reset got busy=%b fflags=%b exp 1/00011", busy, fflags); else n_pass++;
    rst_n = 1'b0;
    req_valid = 1'b1; req_op = OP_FADD; req_tag = 4'd8;
    #1;
    n_total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL mid_reset_ctl got busy=%b valid=%b ready=%b exp 0/0/1", busy, rsp_valid, req_ready); else n_pass++;
    n_total++; if (dp_a !== 32'h0 || dp_b !== 32'h0 || dp_op !== 4'h0 || dp_start !== 1'b0) $display("FAIL mid_reset_dp got a=%h b=%h op=%h exp 0", dp_a, dp_b, dp_op); else n_pass++;
    n_total++; if (fflags !== 5'b0 || rsp_result !== 32'h0 || rsp_flags !== 5'b0 || rsp_tag !== 4'h0) $display("FAIL mid_reset_rsp got fflags=%b res=%h fl=%b tag=%0d exp 0", fflags, rsp_result, rsp_flags, rsp_tag); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_no_accept got busy=%b exp=0", busy); else n_pass++;
    rst_n = 1'b1;
    req_valid = 1'b0;
    sb.delete();
    exp_fflags = 5'b00000;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_total++; if (bad) $display("FAIL dropped_op got valid=%b busy=%b exp 0/0", rsp_valid, busy); else n_pass++;
    issue(OP_FADD, 32'h3F800000, 32'h40000000, 32'h0, 4'hA, 5'b00000, t, ok);
    wait_rsp(tr, ok);
    n_total++; if (!ok || tr != t + 4) $display("FAIL post_reset_cycle got=%0d exp=%0d", tr - t, 4); else n_pass++;
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      n_total++; if (rsp_result !== e.res || rsp_tag !== e.tag) $display("FAIL post_reset_rsp got=%h/%0d exp=%h/%0d", rsp_result, rsp_tag, e.res, e.tag); else n_pass++;
    end
    n_total++; if (fflags !== exp_fflags) $display("FAIL post_reset_fflags got=%b exp=%b", fflags, exp_fflags); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int t1, t2, tr1, tr2, n, exp_gap; bit ok, got1; exp_t e;
    logic [31:0] r1_res; logic [4:0] r1_fl; logic [3:0] r1_tag;
`ifdef FPU_SEQ_BACK2BACK_EN
    exp_gap = 5;
`else
    exp_gap = 6;
`endif
    rsp_ready = 1'b1;
    issue(OP_FMUL, 32'h11111111, 32'h22222222, 32'h33333333, 4'd1, 5'b00000, t1, ok);
    req_valid = 1'b1; req_op = OP_FMUL; req_a = 32'hA5A5A5A5; req_b = 32'h5A5A0000; req_c = 32'h1; req_tag = 4'd2;
    got1 = 1'b0; tr1 = 0; r1_res = '0; r1_fl = '0; r1_tag = '0;
    n = 0;
    while (n < 50) begin
      if (rsp_valid && !got1) begin
        got1 = 1'b1; tr1 = cyc; r1_res = rsp_result; r1_fl = rsp_flags; r1_tag = rsp_tag;
      end
      if (req_ready) break;
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    ok = req_ready;
    if (ok) begin
      sb.push_back('{res: tb_res(OP_FMUL, 32'hA5A5A5A5, 32'h5A5A0000, 32'h1), fl: 5'b00010, tag: 4'd2});
      tb_flags = 5'b00010;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_total++; if (!ok || t2 != t1 + exp_gap) $display("FAIL b2b_accept_cycle got=%0d exp=%0d", t2 - t1, exp_gap); else n_pass++;
    n_total++; if (!got1 || tr1 != t1 + 5) $display("FAIL b2b_rsp1_cycle got=%0d exp=%0d", tr1 - t1, 5); else n_pass++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++; if (r1_res !== e.res || r1_fl !== e.fl || r1_tag !== e.tag) $display("FAIL b2b_rsp1 got=%h/%b/%0d exp=%h/%b/%0d", r1_res, r1_fl, r1_tag, e.res, e.fl, e.tag); else n_pass++;
    end
    wait_rsp(tr2, ok);
    n_total++; if (!ok || tr2 != t2 + 5) $display("FAIL b2b_rsp2_cycle got=%0d exp=%0d", tr2 - t2, 5); else n_pass++;
    if (ok && sb.size() > 0) begin
      e = sb.pop_front();
      n_total++; if (rsp_result !== e.res || rsp_flags !== e.fl || rsp_tag !== e.tag) $display("FAIL b2b_rsp2 got=%h/%b/%0d exp=%h/%b/%0d", rsp_result, rsp_flags, rsp_tag, e.res, e.fl, e.tag); else n_pass++;
    end
    exp_fflags = exp_fflags | 5'b00010;
    n_total++; if (fflags !== exp_fflags) $display("FAIL b2b_fflags got=%b exp=%b", fflags, exp_fflags); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_fadd();
    test_fdiv_sticky();
    test_stall();
    test_csr();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
